// File: rtl/csrfile_pkg.sv
// Shared definitions for the machine-mode CSR file: implemented addresses,
// status/interrupt bit positions and writable masks.
package csrfile_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_addr_t;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;

    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    // mtvec and mepc both drop the two low address bits
    function automatic logic [31:0] align4(input logic [31:0] value);
        return value & ALIGN4_MASK;
    endfunction

endpackage

// File: rtl/csrfile_if.sv
// Execute read port, commit update port, interrupt lines and exported trap
// state of the CSR file. master = pipeline side, slave = csrfile.
interface csrfile_if #(
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int REG_DATA_WIDTH = 32,
    parameter int COMMIT_WIDTH   = 4
);
    localparam int RC_W = $clog2(COMMIT_WIDTH + 1);

    logic [CSR_ADDR_WIDTH-1:0] excsr_csrf_addr;
    logic [REG_DATA_WIDTH-1:0] csrf_excsr_data;

    logic                      commit_csrf_we;
    logic [CSR_ADDR_WIDTH-1:0] commit_csrf_waddr;
    logic [REG_DATA_WIDTH-1:0] commit_csrf_wdata;
    logic [RC_W-1:0]           commit_csrf_retire_count;
    logic                      commit_csrf_trap;
    logic [REG_DATA_WIDTH-1:0] commit_csrf_trap_cause;
    logic [REG_DATA_WIDTH-1:0] commit_csrf_trap_pc;
    logic [REG_DATA_WIDTH-1:0] commit_csrf_trap_tval;
    logic                      commit_csrf_mret;

    logic                      ext_msip;
    logic                      ext_mtip;
    logic                      ext_meip;

    logic [REG_DATA_WIDTH-1:0] csrf_mtvec;
    logic [REG_DATA_WIDTH-1:0] csrf_mepc;
    logic                      csrf_mstatus_mie;
    logic                      csrf_int_pending;

    modport master (
        output excsr_csrf_addr,
        input  csrf_excsr_data,
        output commit_csrf_we, commit_csrf_waddr, commit_csrf_wdata,
        output commit_csrf_retire_count,
        output commit_csrf_trap, commit_csrf_trap_cause,
        output commit_csrf_trap_pc, commit_csrf_trap_tval,
        output commit_csrf_mret,
        output ext_msip, ext_mtip, ext_meip,
        input  csrf_mtvec, csrf_mepc, csrf_mstatus_mie, csrf_int_pending
    );

    modport slave (
        input  excsr_csrf_addr,
        output csrf_excsr_data,
        input  commit_csrf_we, commit_csrf_waddr, commit_csrf_wdata,
        input  commit_csrf_retire_count,
        input  commit_csrf_trap, commit_csrf_trap_cause,
        input  commit_csrf_trap_pc, commit_csrf_trap_tval,
        input  commit_csrf_mret,
        input  ext_msip, ext_mtip, ext_meip,
        output csrf_mtvec, csrf_mepc, csrf_mstatus_mie, csrf_int_pending
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter split into two writable halves; a written half wins over
// the increment, and writing the low half suppresses the carry into the high.
module csr_counter64 #(
    parameter int DATA_W = 32,
    parameter int INC_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INC_W-1:0]  inc,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [2*DATA_W-1:0] sum;

    always_comb begin
        sum  = {hi_q, lo_q} + (2*DATA_W)'(inc);
        lo_d = sum[DATA_W-1:0];
        hi_d = sum[2*DATA_W-1:DATA_W];
        if (wr_lo) begin
            lo_d = wdata;
            hi_d = hi_q;
        end
        if (wr_hi) begin
            hi_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: rtl/csrfile.sv
// Machine-mode CSR file: zero-latency read port for execute, commit-time
// writes, trap entry / mret updates and the mcycle/minstret counters.
module csrfile
    import csrfile_pkg::*;
#(
    parameter int                          CSR_ADDR_WIDTH = 12,
    parameter int                          REG_DATA_WIDTH = 32,
    parameter int                          COMMIT_WIDTH   = 4,
    parameter logic [REG_DATA_WIDTH-1:0]   MISA_VALUE     = 32'h4000_1100,
    parameter logic [REG_DATA_WIDTH-1:0]   MTVEC_RESET    = 32'h8000_0000
) (
    input  logic      clk,
    input  logic      rst,
    csrfile_if.slave  bus
);

    localparam int RC_W = $clog2(COMMIT_WIDTH + 1);

    logic [CSR_ADDR_WIDTH-1:0] raddr;
    logic [CSR_ADDR_WIDTH-1:0] waddr;
    logic [REG_DATA_WIDTH-1:0] wdata;
    logic [RC_W-1:0]           retire_count;
    logic                      trap;
    logic                      mret;
    logic                      csr_wr;

    logic                      mstatus_mie_q, mstatus_mie_d;
    logic                      mstatus_mpie_q, mstatus_mpie_d;
    logic [REG_DATA_WIDTH-1:0] mie_reg_q, mie_reg_d;
    logic [REG_DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [REG_DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [REG_DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [REG_DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic [REG_DATA_WIDTH-1:0] mtval_q, mtval_d;

    logic [REG_DATA_WIDTH-1:0] mstatus_val;
    logic [REG_DATA_WIDTH-1:0] mip_val;
    logic [REG_DATA_WIDTH-1:0] rdata;

    logic [REG_DATA_WIDTH-1:0] mcycle_lo, mcycle_hi;
    logic [REG_DATA_WIDTH-1:0] minstret_lo, minstret_hi;

    assign raddr        = bus.excsr_csrf_addr;
    assign waddr        = bus.commit_csrf_waddr;
    assign wdata        = bus.commit_csrf_wdata;
    assign retire_count = bus.commit_csrf_retire_count;
    assign trap         = bus.commit_csrf_trap;
    assign mret         = bus.commit_csrf_mret;

    // A CSR instruction write only lands when neither trap nor mret retires
    assign csr_wr = bus.commit_csrf_we & ~trap & ~mret;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_reg_d      = mie_reg_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mscratch_d     = mscratch_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap) begin
            mepc_d         = align4(bus.commit_csrf_trap_pc);
            mcause_d       = bus.commit_csrf_trap_cause;
            mtval_d        = bus.commit_csrf_trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (waddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wdata[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_reg_d  = wdata & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = align4(wdata);
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = align4(wdata);
                CSR_MCAUSE:   mcause_d   = wdata;
                CSR_MTVAL:    mtval_d    = wdata;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_reg_q      <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mscratch_q     <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_reg_q      <= mie_reg_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mscratch_q     <= mscratch_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    csr_counter64 #(
        .DATA_W (REG_DATA_WIDTH),
        .INC_W  (1)
    ) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_wr && (waddr == CSR_MCYCLE)),
        .wr_hi (csr_wr && (waddr == CSR_MCYCLEH)),
        .wdata (wdata),
        .lo    (mcycle_lo),
        .hi    (mcycle_hi)
    );

    csr_counter64 #(
        .DATA_W (REG_DATA_WIDTH),
        .INC_W  (RC_W)
    ) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_count),
        .wr_lo (csr_wr && (waddr == CSR_MINSTRET)),
        .wr_hi (csr_wr && (waddr == CSR_MINSTRETH)),
        .wdata (wdata),
        .lo    (minstret_lo),
        .hi    (minstret_hi)
    );

    // MPP is hardwired to machine mode, so it always reads 2'b11
    always_comb begin
        mstatus_val                         = '0;
        mstatus_val[MSTATUS_MPP_LO +: 2]    = 2'b11;
        mstatus_val[MSTATUS_MIE_BIT]        = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT]       = mstatus_mpie_q;
        mip_val                             = '0;
        mip_val[MIP_MSIP_BIT]               = bus.ext_msip;
        mip_val[MIP_MTIP_BIT]               = bus.ext_mtip;
        mip_val[MIP_MEIP_BIT]               = bus.ext_meip;
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CSR_MSTATUS:   rdata = mstatus_val;
            CSR_MISA:      rdata = MISA_VALUE;
            CSR_MIE:       rdata = mie_reg_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip_val;
            CSR_MCYCLE:    rdata = mcycle_lo;
            CSR_MCYCLEH:   rdata = mcycle_hi;
            CSR_MINSTRET:  rdata = minstret_lo;
            CSR_MINSTRETH: rdata = minstret_hi;
            CSR_MVENDORID: rdata = '0;
            CSR_MARCHID:   rdata = '0;
            CSR_MIMPID:    rdata = '0;
            CSR_MHARTID:   rdata = '0;
            default:       rdata = '0;
        endcase
    end

    assign bus.csrf_excsr_data  = rdata;
    assign bus.csrf_mtvec       = mtvec_q;
    assign bus.csrf_mepc        = mepc_q;
    assign bus.csrf_mstatus_mie = mstatus_mie_q;
    assign bus.csrf_int_pending = (|(mip_val & mie_reg_q)) & mstatus_mie_q;

endmodule

// File: tb/tb_csrfile.sv
// Self-checking bench for csrfile: expected CSR reads are queued as stimulus
// is applied and compared when the combinational read port is sampled.
module tb_csrfile;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    csrfile_if bus ();

    csrfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [11:0] addr;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sbQueue[$];
    int numChecks = 0;
    int numFails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expectRead(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        sb_entry_t e;
        e.tag  = tag;
        e.addr = addr;
        e.exp  = exp;
        sbQueue.push_back(e);
    endtask

    // Each queued read is driven onto the port and sampled 1ns later
    task automatic drainReads();
        sb_entry_t e;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            bus.excsr_csrf_addr = e.addr;
            #1;
            checkOutput(e.tag, bus.csrf_excsr_data, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearCommit();
        bus.commit_csrf_we           = 1'b0;
        bus.commit_csrf_waddr        = '0;
        bus.commit_csrf_wdata        = '0;
        bus.commit_csrf_retire_count = '0;
        bus.commit_csrf_trap         = 1'b0;
        bus.commit_csrf_trap_cause   = '0;
        bus.commit_csrf_trap_pc      = '0;
        bus.commit_csrf_trap_tval    = '0;
        bus.commit_csrf_mret         = 1'b0;
    endtask

    // Drive one commit cycle (trap payload set beforehand by the caller)
    task automatic applyStimulus(input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                                 input logic [2:0] retire, input logic trap, input logic mret);
        bus.commit_csrf_we           = we;
        bus.commit_csrf_waddr        = waddr;
        bus.commit_csrf_wdata        = wdata;
        bus.commit_csrf_retire_count = retire;
        bus.commit_csrf_trap         = trap;
        bus.commit_csrf_mret         = mret;
        tick();
        clearCommit();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearCommit();
        bus.excsr_csrf_addr = '0;
        bus.ext_msip = 1'b0;
        bus.ext_mtip = 1'b0;
        bus.ext_meip = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_mtvec_out", bus.csrf_mtvec, 32'h8000_0000);
        checkOutput("rst_mepc_out", bus.csrf_mepc, 32'h0);
        checkOutput("rst_mie_out", {31'b0, bus.csrf_mstatus_mie}, 32'h0);
        checkOutput("rst_intpend", {31'b0, bus.csrf_int_pending}, 32'h0);
        expectRead("rst_mtvec", 12'h305, 32'h8000_0000);
        expectRead("rst_misa", 12'h301, 32'h4000_1100);
        expectRead("rst_mstatus", 12'h300, 32'h0000_1800);
        expectRead("rst_unimpl", 12'h7C0, 32'h0);
        expectRead("rst_mcycle", 12'hB00, 32'h0);
        drainReads();

        $display("[TB] write/read timing");
        bus.commit_csrf_we    = 1'b1;
        bus.commit_csrf_waddr = 12'h340;
        bus.commit_csrf_wdata = 32'hDEAD_BEEF;
        expectRead("scratch_same_cycle", 12'h340, 32'h0);
        drainReads();
        tick();
        clearCommit();
        expectRead("scratch_next_cycle", 12'h340, 32'hDEAD_BEEF);
        drainReads();
        applyStimulus(1'b1, 12'h305, 32'h8000_0007, 3'd0, 1'b0, 1'b0);
        expectRead("mtvec_align", 12'h305, 32'h8000_0004);
        drainReads();
        checkOutput("mtvec_out", bus.csrf_mtvec, 32'h8000_0004);

        $display("[TB] masks and read-only registers");
        applyStimulus(1'b1, 12'h304, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'h344, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'h301, 32'h0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'h7C0, 32'h1234, 3'd0, 1'b0, 1'b0);
        expectRead("mie_mask", 12'h304, 32'h0000_0888);
        expectRead("mip_ro", 12'h344, 32'h0);
        expectRead("misa_ro", 12'h301, 32'h4000_1100);
        expectRead("unimpl_wr", 12'h7C0, 32'h0);
        expectRead("mhartid", 12'hF14, 32'h0);
        drainReads();

        $display("[TB] trap and mret");
        applyStimulus(1'b1, 12'h300, 32'h8, 3'd0, 1'b0, 1'b0);
        expectRead("mstatus_mie_set", 12'h300, 32'h0000_1808);
        drainReads();
        bus.commit_csrf_trap_cause = 32'd2;
        bus.commit_csrf_trap_pc    = 32'h1002;
        bus.commit_csrf_trap_tval  = 32'h13;
        applyStimulus(1'b0, 12'h0, 32'h0, 3'd0, 1'b1, 1'b0);
        expectRead("trap_mepc", 12'h341, 32'h1000);
        expectRead("trap_mcause", 12'h342, 32'd2);
        expectRead("trap_mtval", 12'h343, 32'h13);
        expectRead("trap_mstatus", 12'h300, 32'h0000_1880);
        drainReads();
        checkOutput("trap_mie_out", {31'b0, bus.csrf_mstatus_mie}, 32'h0);
        checkOutput("trap_mepc_out", bus.csrf_mepc, 32'h1000);
        applyStimulus(1'b0, 12'h0, 32'h0, 3'd0, 1'b0, 1'b1);
        expectRead("mret_mstatus", 12'h300, 32'h0000_1888);
        drainReads();
        checkOutput("mret_mie_out", {31'b0, bus.csrf_mstatus_mie}, 32'h1);

        $display("[TB] trap > mret > write priority");
        bus.commit_csrf_trap_cause = 32'hB;
        bus.commit_csrf_trap_pc    = 32'h2000;
        bus.commit_csrf_trap_tval  = 32'h0;
        applyStimulus(1'b1, 12'h340, 32'h5, 3'd0, 1'b1, 1'b1);
        expectRead("prio_mscratch", 12'h340, 32'hDEAD_BEEF);
        expectRead("prio_mstatus", 12'h300, 32'h0000_1880);
        expectRead("prio_mepc", 12'h341, 32'h2000);
        expectRead("prio_mcause", 12'h342, 32'hB);
        drainReads();

        $display("[TB] counters");
        applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
        tick();
        expectRead("mcycle_carry_lo", 12'hB00, 32'h0);
        expectRead("mcycle_carry_hi", 12'hB80, 32'h1);
        drainReads();
        applyStimulus(1'b1, 12'hB80, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
        tick();
        expectRead("mcycle_wrap_lo", 12'hB00, 32'h0);
        expectRead("mcycle_wrap_hi", 12'hB80, 32'h0);
        drainReads();
        applyStimulus(1'b1, 12'hB02, 32'hFFFF_FFFE, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'hB82, 32'h7, 3'd4, 1'b0, 1'b0);
        expectRead("minstret_wrhi_lo", 12'hB02, 32'h2);
        expectRead("minstret_wrhi_hi", 12'hB82, 32'h7);
        drainReads();
        applyStimulus(1'b1, 12'hB02, 32'hFFFF_FFFD, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 12'h0, 32'h0, 3'd4, 1'b0, 1'b0);
        expectRead("minstret_carry_lo", 12'hB02, 32'h1);
        expectRead("minstret_carry_hi", 12'hB82, 32'h8);
        drainReads();

        $display("[TB] interrupts");
        applyStimulus(1'b1, 12'h304, 32'h80, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'h300, 32'h8, 3'd0, 1'b0, 1'b0);
        checkOutput("int_idle", {31'b0, bus.csrf_int_pending}, 32'h0);
        bus.ext_msip = 1'b1;
        #1;
        checkOutput("int_msip_masked", {31'b0, bus.csrf_int_pending}, 32'h0);
        bus.ext_mtip = 1'b1;
        #1;
        checkOutput("int_mtip", {31'b0, bus.csrf_int_pending}, 32'h1);
        expectRead("mip_live", 12'h344, 32'h88);
        drainReads();
        applyStimulus(1'b1, 12'h300, 32'h0, 3'd0, 1'b0, 1'b0);
        checkOutput("int_gie_off", {31'b0, bus.csrf_int_pending}, 32'h0);
        bus.ext_msip = 1'b0;
        bus.ext_mtip = 1'b0;

        $display("[TB] reset overrides commit");
        rst = 1'b1;
        bus.commit_csrf_trap_pc = 32'h3000;
        applyStimulus(1'b1, 12'h340, 32'h9, 3'd4, 1'b1, 1'b1);
        rst = 1'b0;
        expectRead("rst2_mscratch", 12'h340, 32'h0);
        expectRead("rst2_mepc", 12'h341, 32'h0);
        expectRead("rst2_mstatus", 12'h300, 32'h0000_1800);
        expectRead("rst2_mtvec", 12'h305, 32'h8000_0000);
        expectRead("rst2_mcycle", 12'hB00, 32'h0);
        expectRead("rst2_minstret", 12'hB02, 32'h0);
        drainReads();
        checkOutput("rst2_mepc_out", bus.csrf_mepc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
